// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared constants for the accumulator datapath: command
//               encodings and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    // Command encodings carried on i_Cmd
    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_LDI  = 3'b001;
    localparam logic [2:0] CMD_LD   = 3'b010;
    localparam logic [2:0] CMD_ADDI = 3'b011;
    localparam logic [2:0] CMD_ADD  = 3'b100;
    localparam logic [2:0] CMD_SUBI = 3'b101;
    localparam logic [2:0] CMD_SUB  = 3'b110;
    localparam logic [2:0] CMD_ST   = 3'b111;

    // Datapath sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_datapath_sign_ext.sv
`default_nettype none
// ============================================================================
// Module      : operand_sign_ext
// Description : Sign-extends an OPND_BITS immediate to NBITS. If the
//               immediate is at least as wide as the target it is truncated.
// Ports       : i_Operand  [OPND_BITS-1:0]  raw immediate field
//               o_Extended [NBITS-1:0]      sign-extended value
// Revision    : 1.0 - initial release
// ============================================================================
module operand_sign_ext #(
    parameter int NBITS     = 16,
    parameter int OPND_BITS = 11
) (
    input  logic [OPND_BITS-1:0] i_Operand,
    output logic [NBITS-1:0]     o_Extended
);

    generate
        if (NBITS > OPND_BITS) begin : g_extend
            assign o_Extended = {{(NBITS-OPND_BITS){i_Operand[OPND_BITS-1]}}, i_Operand};
        end else begin : g_truncate
            assign o_Extended = i_Operand[NBITS-1:0];
        end
    endgenerate

endmodule : operand_sign_ext
`default_nettype wire

// File: rtl/acc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : acc_datapath
// Description : Accumulator datapath. Accepts one command per valid/ready
//               handshake, executes immediates in a single cycle, sequences
//               data-memory reads (LD/ADD/SUB) and writes (ST), and keeps the
//               Zero/Neg/Ovf status flags.
// Ports       : i_clk, i_rst_n           clock, async active-low reset
//               i_Valid/o_Ready          command handshake
//               i_Cmd, i_Operand         command and immediate/address
//               o_MemAddr/o_MemRd/o_MemWr/o_MemWrData/i_MemRdData
//                                        data-memory interface
//               o_Acc, o_Done            accumulator, completion pulse
//               o_Zero, o_Neg, o_Ovf     status flags
// Revision    : 1.0 - initial release
// ============================================================================
module acc_datapath
    import acc_pkg::*;
#(
    parameter int NBITS     = 16,
    parameter int ADDR_BITS = 11,
    parameter int OPND_BITS = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic [2:0]           i_Cmd,
    input  logic [OPND_BITS-1:0] i_Operand,
    output logic [ADDR_BITS-1:0] o_MemAddr,
    output logic                 o_MemRd,
    output logic                 o_MemWr,
    output logic [NBITS-1:0]     o_MemWrData,
    input  logic [NBITS-1:0]     i_MemRdData,
    output logic [NBITS-1:0]     o_Acc,
    output logic                 o_Done,
    output logic                 o_Zero,
    output logic                 o_Neg,
    output logic                 o_Ovf
);

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [2:0]           r_cmd;
    logic [ADDR_BITS-1:0] r_addr;
    logic [NBITS-1:0]     r_acc;
    logic                 r_ovf;
    logic                 r_done;

    logic                 w_accept;
    logic [ADDR_BITS-1:0] w_addr;
    logic [NBITS-1:0]     w_imm;
    logic [NBITS-1:0]     w_opnd;
    logic [NBITS-1:0]     w_sum;
    logic [NBITS-1:0]     w_diff;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;

    assign w_accept = i_Valid && (r_state == ST_IDLE);

    // Address field: truncate or zero-extend the operand to ADDR_BITS
    generate
        if (OPND_BITS >= ADDR_BITS) begin : g_addr_trunc
            assign w_addr = i_Operand[ADDR_BITS-1:0];
        end else begin : g_addr_zext
            assign w_addr = {{(ADDR_BITS-OPND_BITS){1'b0}}, i_Operand};
        end
    endgenerate

    operand_sign_ext #(
        .NBITS     (NBITS),
        .OPND_BITS (OPND_BITS)
    ) u_sign_ext (
        .i_Operand  (i_Operand),
        .o_Extended (w_imm)
    );

    // Immediates execute from IDLE straight off the input; memory forms
    // execute in WAIT using the returned read data.
    assign w_opnd = (r_state == ST_WAIT) ? i_MemRdData : w_imm;
    assign w_sum  = r_acc + w_opnd;
    assign w_diff = r_acc - w_opnd;

    assign w_add_ovf = (r_acc[NBITS-1] == w_opnd[NBITS-1]) &&
                       (w_sum[NBITS-1] != r_acc[NBITS-1]);
    assign w_sub_ovf = (r_acc[NBITS-1] != w_opnd[NBITS-1]) &&
                       (w_diff[NBITS-1] != r_acc[NBITS-1]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_Valid) begin
                    case (i_Cmd)
                        CMD_LD, CMD_ADD, CMD_SUB: w_next = ST_RD;
                        CMD_ST:                   w_next = ST_WR;
                        default:                  w_next = ST_IDLE;
                    endcase
                end
            end
            ST_RD:   w_next = ST_WAIT;
            ST_WAIT: w_next = ST_IDLE;
            ST_WR:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_Ready = 1'b0;
        o_MemRd = 1'b0;
        o_MemWr = 1'b0;
        case (r_state)
            ST_IDLE: o_Ready = 1'b1;
            ST_RD:   o_MemRd = 1'b1;
            ST_WR:   o_MemWr = 1'b1;
            default: o_Ready = 1'b0;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd  <= i_Cmd;
                        r_addr <= w_addr;
                        case (i_Cmd)
                            CMD_NOP: begin
                                r_done <= 1'b1;
                            end
                            CMD_LDI: begin
                                r_acc  <= w_imm;
                                r_ovf  <= 1'b0;
                                r_done <= 1'b1;
                            end
                            CMD_ADDI: begin
                                r_acc  <= w_sum;
                                r_ovf  <= w_add_ovf;
                                r_done <= 1'b1;
                            end
                            CMD_SUBI: begin
                                r_acc  <= w_diff;
                                r_ovf  <= w_sub_ovf;
                                r_done <= 1'b1;
                            end
                            default: r_done <= 1'b0;
                        endcase
                    end
                end
                ST_WAIT: begin
                    r_done <= 1'b1;
                    case (r_cmd)
                        CMD_LD: begin
                            r_acc <= i_MemRdData;
                            r_ovf <= 1'b0;
                        end
                        CMD_ADD: begin
                            r_acc <= w_sum;
                            r_ovf <= w_add_ovf;
                        end
                        CMD_SUB: begin
                            r_acc <= w_diff;
                            r_ovf <= w_sub_ovf;
                        end
                        default: r_acc <= r_acc;
                    endcase
                end
                ST_WR:   r_done <= 1'b1;
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign o_MemAddr   = r_addr;
    assign o_MemWrData = r_acc;
    assign o_Acc       = r_acc;
    assign o_Done      = r_done;
    assign o_Zero      = (r_acc == '0);
    assign o_Neg       = r_acc[NBITS-1];
    assign o_Ovf       = r_ovf;

endmodule : acc_datapath
`default_nettype wire

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
Accumulator datapath for the accumulator CPU. It drives the ACC and operand inputs of the add/sub arithmetic and captures its result back into ACC. It accepts one command per valid/ready handshake from the control unit. It sequences data-memory reads and writes for LD, ADD, SUB and ST, and produces Zero, Neg and Ovf status flags.

Parameters:
NBITS, 16, accumulator and data-memory word width
ADDR_BITS, 11, data-memory address width
OPND_BITS, 11, instruction operand field width (immediate or address)

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_Valid  in  1  command valid
o_Ready  out  1  block can accept a command
i_Cmd  in  3  000 NOP, 001 LDI, 010 LD, 011 ADDI, 100 ADD, 101 SUBI, 110 SUB, 111 ST
i_Operand  in  OPND_BITS  immediate (LDI/ADDI/SUBI) or memory address (LD/ADD/SUB/ST)
o_MemAddr  out  ADDR_BITS  registered data-memory address
o_MemRd  out  1  read strobe, 1 cycle; data is valid on i_MemRdData the following cycle
o_MemWr  out  1  write strobe, 1 cycle
o_MemWrData  out  NBITS  write data (ACC)
i_MemRdData  in  NBITS  read data
o_Acc  out  NBITS  accumulator value
o_Done  out  1  1-cycle pulse on command completion
o_Zero  out  1  ACC == 0
o_Neg  out  1  ACC[NBITS-1]
o_Ovf  out  1  signed overflow of the last ADD/ADDI/SUB/SUBI

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values:
  - All outputs 0, except o_Ready = 1 once the block is in IDLE.
  - o_Zero = 1, because ACC = 0.
  - State = IDLE.
- Handshake:
  - A command is accepted on a rising edge where i_Valid && o_Ready.
  - i_Valid while o_Ready = 0 is ignored; nothing is queued.
  - i_Cmd and i_Operand are captured on acceptance and need not be held afterwards.
- FSM states: IDLE, RD, WAIT, WR.
  - IDLE, o_Ready = 1:
    - Accepted NOP/LDI/ADDI/SUBI: execute on the accept edge; stay in IDLE; o_Done pulses the next cycle.
    - Accepted LD/ADD/SUB: go to RD.
    - Accepted ST: go to WR.
  - RD, o_Ready = 0: o_MemRd = 1, o_MemAddr = captured address. Go to WAIT.
  - WAIT, o_Ready = 0: sample i_MemRdData and apply LD/ADD/SUB to ACC at the end of the cycle. Go to IDLE. o_Done pulses in the first IDLE cycle.
  - WR, o_Ready = 0: o_MemWr = 1, o_MemAddr = address, o_MemWrData = ACC. Go to IDLE with an o_Done pulse. ACC and flags are unchanged.
- Latency, accept edge to o_Done high:
  - Immediate commands and NOP: 1 cycle.
  - LD/ADD/SUB: 3 cycles.
  - ST: 2 cycles.
- Back-to-back immediate commands run at 1 per cycle, and o_Done can stay high across consecutive cycles.
- Widths:
  - Immediate is sign-extended from OPND_BITS to NBITS.
  - Address is i_Operand[ADDR_BITS-1:0]; when OPND_BITS < ADDR_BITS it is zero-extended.
  - Add/sub wraps modulo 2^NBITS, two's complement.
- Flags:
  - o_Zero and o_Neg always reflect the current ACC.
  - o_Ovf for ADD: operands have the same sign and the result sign differs.
  - o_Ovf for SUB: operand signs differ and the result sign differs from ACC.
  - LD/LDI clear o_Ovf.
  - NOP and ST leave o_Ovf unchanged.
- Memory strobes are never asserted outside RD (o_MemRd) and WR (o_MemWr). o_MemRd and o_MemWr are never both high.
- Reset mid-operation (any state): return to IDLE immediately and clear ACC. Any pending read result is discarded, no write occurs after the reset edge, and o_Done is not pulsed.

Decomposition:
- Shared package acc_pkg holds:
  - cmd encoding constants CMD_NOP … CMD_ST
  - state encoding constants ST_IDLE, ST_RD, ST_WAIT, ST_WR
- Natural sub-module: operand_sign_ext (parameterised OPND_BITS → NBITS sign extension).
- The add/sub and overflow logic stays inline.

Test Plan:
1. Reset: assert i_rst_n = 0 for 3 cycles, then release → o_Acc = 0x0000, o_Zero = 1, o_Ready = 1, all strobes 0.
2. LDI 0x3FF, then ADDI 0x7FF (−1) → ACC = 0x03FF, then ACC = 0x03FE; each o_Done comes 1 cycle after accept; o_Ovf = 0.
3. LDI 0x001, then ADD addr 0x005 with mem[5] = 0x7FFF:
   - o_MemRd = 1 with o_MemAddr = 0x005 one cycle after accept.
   - o_Ready = 0 for 2 cycles.
   - ACC = 0x8000 with o_Neg = 1, o_Ovf = 1; o_Done 3 cycles after accept.
4. ACC = 0x8000, SUBI 0x001 → ACC = 0x7FFF, o_Ovf = 1. Then LDI 0 and SUBI 1 → ACC = 0xFFFF, o_Neg = 1, o_Ovf = 0.
5. ACC = 0x1234, ST addr 0x010 → one cycle with o_MemWr = 1, o_MemAddr = 0x010, o_MemWrData = 0x1234. ACC and flags are unchanged, and i_Valid held during WR is not accepted.
6. LD addr 0x002 with reset asserted during WAIT → state returns to IDLE, ACC = 0, no o_Done, o_MemRd = 0. The next LDI 0x005 executes normally.
